// File: rtl/range_slicer.sv
// range_slicer: per-lane range filter / clamp on a valid-ready stream, with a small
// register file, beat/in-range counters and a beat-count threshold interrupt.
//
// Each accepted beat is split into NL = DATA_W/LANE_W unsigned lanes. Every lane is
// compared against LOWER/UPPER and passed, zeroed or clamped according to MODE. The
// processed beat lands in a 2-entry FIFO that feeds the output stream.
//
// Ports:
//   i_user_clk        the only clock
//   i_rst             asynchronous active-high reset
//   i_user_data       register write data (32 bits)
//   i_user_addr       register byte address, decoded on bits [7:0]
//   i_user_wr_req     register write strobe
//   i_user_rd_req     register read strobe
//   o_user_data       read data, valid while o_user_rd_ack is high
//   o_user_rd_ack     read data valid, one cycle after i_user_rd_req
//   i_str_data_valid  input beat valid
//   o_str_ack         input ready (registered, high while the FIFO has room)
//   i_str_data        input beat
//   o_str_data_valid  output beat valid (FIFO not empty)
//   i_str_ack         output ready
//   o_str_data        output beat (FIFO head)
//   o_intr_req        interrupt request (BEATS reached THRESH)
//   i_intr_ack        interrupt acknowledge
//
// Register map (LANE_W-bit fields right-aligned in 32 bits):
//   0x00 LOWER RW, 0x04 UPPER RW, 0x08 MODE RW, 0x0C BEATS RO (write clears),
//   0x10 INRANGE RO (write clears), 0x14 THRESH RW (32 bits). Others read as 0.
module range_slicer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              i_user_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_user_data,
  input  logic [ADDR_W-1:0] i_user_addr,
  input  logic              i_user_wr_req,
  input  logic              i_user_rd_req,
  output logic [31:0]       o_user_data,
  output logic              o_user_rd_ack,
  input  logic              i_str_data_valid,
  output logic              o_str_ack,
  input  logic [DATA_W-1:0] i_str_data,
  output logic              o_str_data_valid,
  input  logic              i_str_ack,
  output logic [DATA_W-1:0] o_str_data,
  output logic              o_intr_req,
  input  logic              i_intr_ack
);

  localparam int unsigned NL   = DATA_W / LANE_W;
  localparam int unsigned CntW = $clog2(NL + 1);

  localparam logic [7:0] AddrLower   = 8'h00;
  localparam logic [7:0] AddrUpper   = 8'h04;
  localparam logic [7:0] AddrMode    = 8'h08;
  localparam logic [7:0] AddrBeats   = 8'h0C;
  localparam logic [7:0] AddrInrange = 8'h10;
  localparam logic [7:0] AddrThresh  = 8'h14;

  // Default window is the middle half of the lane range (64..192 for 8-bit lanes).
  localparam logic [LANE_W-1:0] LowerRst = LANE_W'(1 << (LANE_W - 2));
  localparam logic [LANE_W-1:0] UpperRst = LANE_W'(3 << (LANE_W - 2));

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [LANE_W-1:0] lower_q, lower_d;
  logic [LANE_W-1:0] upper_q, upper_d;
  logic [1:0]        mode_q, mode_d;
  logic [31:0]       thresh_q, thresh_d;
  logic [31:0]       beats_q, beats_d;
  logic [31:0]       inrange_q, inrange_d;
  logic              intr_q, intr_d;
  logic              rd_ack_q;
  logic [31:0]       rd_data_q, rd_data_d;

  logic [7:0] addr8;
  logic       wr_lower, wr_upper, wr_mode, wr_beats, wr_inrange, wr_thresh;

  // Only the low address byte is decoded; upper bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_user_addr[ADDR_W-1:8];

  assign addr8      = i_user_addr[7:0];
  assign wr_lower   = i_user_wr_req && (addr8 == AddrLower);
  assign wr_upper   = i_user_wr_req && (addr8 == AddrUpper);
  assign wr_mode    = i_user_wr_req && (addr8 == AddrMode);
  assign wr_beats   = i_user_wr_req && (addr8 == AddrBeats);
  assign wr_inrange = i_user_wr_req && (addr8 == AddrInrange);
  assign wr_thresh  = i_user_wr_req && (addr8 == AddrThresh);

  // ---------------------------------------------------------------------------
  // Lane processing
  // ---------------------------------------------------------------------------
  // Returns {in_range, result} for one lane.
  function automatic logic [LANE_W:0] slice_lane(input logic [LANE_W-1:0] x,
                                                 input logic [LANE_W-1:0] lo,
                                                 input logic [LANE_W-1:0] hi,
                                                 input logic [1:0]        mode);
    logic              below, above, strict;
    logic              hit;
    logic [LANE_W-1:0] y;
    below  = (x < lo);
    above  = (x > hi);
    strict = (x > lo) && (x < hi);
    hit    = 1'b0;
    y      = '0;
    unique case (mode)
      2'd0: begin
        hit = strict;
        y   = strict ? x : '0;
      end
      2'd1: begin
        hit = !below && !above;
        y   = hit ? x : '0;
      end
      2'd2: begin
        // With lo > hi every lane is either below lo or above hi, so the
        // result degenerates to lo / hi without a special case.
        hit = !below && !above;
        if (below) begin
          y = lo;
        end else if (above) begin
          y = hi;
        end else begin
          y = x;
        end
      end
      2'd3: begin
        hit = 1'b1;
        y   = x;
      end
    endcase
    return {hit, y};
  endfunction

  logic [DATA_W-1:0] proc_data;
  logic [CntW-1:0]   hit_cnt;

  always_comb begin
    logic [LANE_W:0] lane_res;
    proc_data = '0;
    hit_cnt   = '0;
    lane_res  = '0;
    for (int i = 0; i < int'(NL); i++) begin
      lane_res = slice_lane(i_str_data[i*LANE_W +: LANE_W], lower_q, upper_q, mode_q);
      proc_data[i*LANE_W +: LANE_W] = lane_res[LANE_W-1:0];
      hit_cnt = hit_cnt + CntW'(lane_res[LANE_W]);
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (2 entries)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              ack_q;
  logic              push, pop;

  // ack_q always equals (count_q < 2) outside reset, so push never overfills.
  assign push = i_str_data_valid && ack_q;
  assign pop  = (count_q != 2'd0) && i_str_ack;

  always_comb begin
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ack_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= proc_data;
      end
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      count_q  <= count_d;
      ack_q    <= (count_d < 2'd2);
    end
  end

  assign o_str_ack        = ack_q;
  assign o_str_data_valid = (count_q != 2'd0);
  assign o_str_data       = mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    lower_d  = wr_lower  ? i_user_data[LANE_W-1:0] : lower_q;
    upper_d  = wr_upper  ? i_user_data[LANE_W-1:0] : upper_q;
    mode_d   = wr_mode   ? i_user_data[1:0]        : mode_q;
    thresh_d = wr_thresh ? i_user_data             : thresh_q;

    // A clear on the same edge as a transfer keeps that beat's contribution.
    beats_d   = (wr_beats   ? 32'd0 : beats_q)   + 32'(push);
    inrange_d = (wr_inrange ? 32'd0 : inrange_q) + (push ? 32'(hit_cnt) : 32'd0);

    // Set wins over acknowledge.
    intr_d = intr_q;
    if (i_intr_ack) begin
      intr_d = 1'b0;
    end
    if ((thresh_q != 32'd0) && (beats_d == thresh_q) && (beats_d != beats_q)) begin
      intr_d = 1'b1;
    end
  end

  always_comb begin
    rd_data_d = 32'd0;
    case (addr8)
      AddrLower:   rd_data_d = 32'(lower_q);
      AddrUpper:   rd_data_d = 32'(upper_q);
      AddrMode:    rd_data_d = 32'(mode_q);
      AddrBeats:   rd_data_d = beats_q;
      AddrInrange: rd_data_d = inrange_q;
      AddrThresh:  rd_data_d = thresh_q;
      default:     rd_data_d = 32'd0;
    endcase
  end

  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) begin
      lower_q   <= LowerRst;
      upper_q   <= UpperRst;
      mode_q    <= 2'd0;
      thresh_q  <= 32'd0;
      beats_q   <= 32'd0;
      inrange_q <= 32'd0;
      intr_q    <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= 32'd0;
    end else begin
      lower_q   <= lower_d;
      upper_q   <= upper_d;
      mode_q    <= mode_d;
      thresh_q  <= thresh_d;
      beats_q   <= beats_d;
      inrange_q <= inrange_d;
      intr_q    <= intr_d;
      rd_ack_q  <= i_user_rd_req;
      if (i_user_rd_req) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign o_user_rd_ack = rd_ack_q;
  assign o_user_data   = rd_data_q;
  assign o_intr_req    = intr_q;

endmodule

// File: doc/range_slicer.md
RANGE_SLICER -- requirements
Module: range_slicer

Interface
REQ-001 Parameters SHALL be: DATA_W default 64, stream beat width; LANE_W default 8, lane width, DATA_W divisible by LANE_W; ADDR_W default 20, register address width.
REQ-002 Ports SHALL be:
- i_user_clk, in, 1: the only clock.
- i_rst, in, 1: asynchronous, active-high reset.
- i_user_data, in, 32: register write data.
- i_user_addr, in, ADDR_W: register byte address.
- i_user_wr_req, in, 1: write strobe.
- i_user_rd_req, in, 1: read strobe.
- o_user_data, out, 32: read data.
- o_user_rd_ack, out, 1: read data valid.
- i_str_data_valid, in, 1: input beat valid.
- o_str_ack, out, 1: input ready.
- i_str_data, in, DATA_W: input beat.
- o_str_data_valid, out, 1: output beat valid.
- i_str_ack, in, 1: output ready.
- o_str_data, out, DATA_W: output beat.
- o_intr_req, out, 1: interrupt request.
- i_intr_ack, in, 1: interrupt acknowledge.

Function
REQ-003 Input transfer SHALL occur on a cycle with i_str_data_valid & o_str_ack; output transfer SHALL occur on a cycle with o_str_data_valid & i_str_ack.
REQ-004 Each accepted beat SHALL be processed per lane (NL = DATA_W/LANE_W unsigned lanes) and written into a 2-entry FIFO.
- o_str_ack = (occupancy < 2), registered.
- o_str_data_valid = (occupancy > 0).
- o_str_data = head entry.
REQ-005 Latency SHALL be 1 cycle from input transfer into an empty FIFO to o_str_data_valid high; beat order SHALL be preserved.
REQ-006 Simultaneous push and pop SHALL leave occupancy unchanged; at occupancy 2 no push occurs; pop at empty is impossible by REQ-004.
REQ-007 MODE[1:0] SHALL select the per-lane function, with x = lane value, L = LOWER, U = UPPER:
- 0: x if L<x<U, else 0.
- 1: x if L<=x<=U, else 0.
- 2 (clamp): L if x<L; else U if x>U; else x.
- 3: x unchanged (bypass).
REQ-008 With L>U, modes 0/1 SHALL output all-zero lanes and mode 2 SHALL output L for x<L, else U.
REQ-009 A lane SHALL count as in-range when the mode 0/1/2 test passes (modes 0 and 1 per their own bounds test; mode 2 uses L<=x<=U); every lane counts as in-range in mode 3.
REQ-010 Registers SHALL be LANE_W-bit fields right-aligned in 32 bits, decoded on i_user_addr[7:0]:
- 0x00 LOWER, RW.
- 0x04 UPPER, RW.
- 0x08 MODE, RW.
- 0x0C BEATS, RO, 32-bit count of input transfers; any write clears it.
- 0x10 INRANGE, RO, 32-bit sum of in-range lanes; any write clears it.
- 0x14 THRESH, RW, 32 bits.
- Writes to RO or unmapped addresses have no effect other than the counter clears.
REQ-011 A write SHALL take effect at the clock edge of i_user_wr_req; a beat accepted on that same edge SHALL use the old configuration.
REQ-012 Reads SHALL assert o_user_rd_ack one cycle after i_user_rd_req, with o_user_data valid that cycle; unmapped addresses return 0x00000000.
REQ-013 BEATS and INRANGE SHALL wrap modulo 2^32; INRANGE increments by 0..NL per beat.
REQ-014 A counter clear coinciding with an input transfer SHALL leave the counter at that beat's contribution.
REQ-015 Interrupt behaviour SHALL be:
- When THRESH != 0 and BEATS transitions to equal THRESH, o_intr_req SHALL set on the next edge.
- o_intr_req SHALL clear on the edge after i_intr_ack is sampled high; set takes priority when both occur.

Reset
REQ-016 While i_rst is high, registers SHALL be asynchronously set to:
- LOWER = 2^(LANE_W-2), UPPER = 3*2^(LANE_W-2) (64/192 for LANE_W 8), MODE = 0, THRESH = 0.
- BEATS = 0, INRANGE = 0, FIFO empty.
- o_str_data_valid = 0, o_str_ack = 0, o_user_rd_ack = 0, o_intr_req = 0, o_user_data = 0, o_str_data = 0.
REQ-017 o_str_ack SHALL rise on the first edge after i_rst deasserts; reset mid-transfer SHALL discard FIFO contents.

Verification
REQ-018 After reset, mode 0, input 0x00_40_41_80_BF_C0_FF_10 with i_str_ack=1 -> output 0x00_00_41_80_BF_00_00_00 one cycle later; INRANGE=3, BEATS=1.
REQ-019 Mode 1 then mode 2 on the same beat -> 0x00_40_41_80_BF_C0_00_00 and 0x40_40_41_80_BF_C0_C0_40 respectively.
REQ-020 Hold i_str_ack=0 and stream 3 beats -> o_str_ack low after 2 accepts; release -> 3 beats out in order, none lost or duplicated.
REQ-021 Write LOWER=0x20 on the same edge as a beat accepted with lane 0x30 -> beat still zeroed; next beat with 0x30 passes.
REQ-022 THRESH=4, send 4 beats -> o_intr_req high 1 cycle after the 4th transfer; pulse i_intr_ack -> cleared; write 0x0C -> BEATS reads 0.
REQ-023 Assert i_rst with the FIFO full -> outputs take reset values immediately; after release, read 0x00 -> o_user_rd_ack next cycle, o_user_data=0x00000040.
